usb_tx: RTL and testbench



---
 rtl/usb_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/usb_tx.sv | 170 +++++++++++++++++
 tb/tb_usb_tx.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared FT245 types, bus-cycle states and 100 MHz timing defaults
package usb_pkg;

   typedef logic [7:0] byte_t;

   // FT245 write-cycle timing at 100 MHz, shared with the receive path
   localparam int unsigned FT_SETUP_CYC = 2;
   localparam int unsigned FT_WR_CYC    = 5;
   localparam int unsigned FT_HOLD_CYC  = 1;
   localparam int unsigned FT_RECOV_CYC = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SETUP,
      ST_WR_HI,
      ST_HOLD,
      ST_RECOV
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterized single-clock FIFO with occupancy output
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q;
   logic             do_push, do_pop;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // byte storage, written at the tail
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // pointers wrap naturally at DEPTH; level tracks push/pop balance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - FT245 write engine: byte FIFO, bus arbitration, WR strobe timing; SI flush under SI_FLUSH_EN
module usb_tx
   import usb_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned SETUP_CYC = FT_SETUP_CYC,
   parameter int unsigned WR_CYC    = FT_WR_CYC,
   parameter int unsigned HOLD_CYC  = FT_HOLD_CYC,
   parameter int unsigned RECOV_CYC = FT_RECOV_CYC
`ifdef SI_FLUSH_EN
   ,
   parameter int unsigned SI_IDLE_CYC  = 1000,
   parameter int unsigned SI_PULSE_CYC = 5
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  byte_t                  tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   input  logic                   txe,
   output logic                   wr,
   output byte_t                  d_out,
   output logic                   d_oe,
   input  logic                   bus_gnt,
   output logic                   bus_busy,
   output logic                   SI,
   output logic [$clog2(DEPTH):0] fifo_level
);
   tx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        wr_q, wr_d, d_oe_q, d_oe_d, bus_busy_q, bus_busy_d;
   byte_t       d_out_q, d_out_d;
   logic        txe_s1_q, txe_s_q;
   logic        push, pop, fifo_full, fifo_empty, si_block;
   byte_t       head;

   assign tx_ready = !fifo_full;
   assign push     = tx_valid && tx_ready;
   assign wr       = wr_q;
   assign d_oe     = d_oe_q;
   assign d_out    = d_out_q;
   assign bus_busy = bus_busy_q;

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_data_i(tx_data),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .level_o    (fifo_level)
   );

   // TXE# is asynchronous to clk; idle-high means "device not ready"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txe_s1_q <= 1'b1;
         txe_s_q  <= 1'b1;
      end else begin
         txe_s1_q <= txe;
         txe_s_q  <= txe_s1_q;
      end
   end

   // bus-cycle sequencing; once REQ is left the cycle runs to completion
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      d_out_d = d_out_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!fifo_empty && !txe_s_q && !si_block) state_d = ST_REQ;
         end
         ST_REQ: begin
            cnt_d = '0;
            if (bus_gnt) begin
               d_out_d = head;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: if (cnt_q == 16'(SETUP_CYC - 1)) begin
            cnt_d   = '0;
            state_d = ST_WR_HI;
         end
         ST_WR_HI: if (cnt_q == 16'(WR_CYC - 1)) begin
            cnt_d   = '0;
            pop     = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: if (cnt_q == 16'(HOLD_CYC - 1)) begin
            cnt_d   = '0;
            state_d = ST_RECOV;
         end
         ST_RECOV: if (cnt_q == 16'(RECOV_CYC - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      wr_d       = (state_d == ST_WR_HI);
      d_oe_d     = (state_d == ST_SETUP) || (state_d == ST_WR_HI) || (state_d == ST_HOLD);
      bus_busy_d = (state_d != ST_IDLE);
   end

   // state and registered bus outputs; reset drops wr/d_oe without a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         d_oe_q     <= 1'b0;
         d_out_q    <= '0;
         bus_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         d_oe_q     <= d_oe_d;
         d_out_q    <= d_out_d;
         bus_busy_q <= bus_busy_d;
      end
   end

`ifdef SI_FLUSH_EN
   logic [31:0] idle_cnt_q, pulse_cnt_q;
   logic        armed_q, pulse_q, idle_tick, pulse_start;

   assign idle_tick   = (state_q == ST_IDLE) && fifo_empty;
   assign pulse_start = armed_q && !pulse_q && idle_tick && (idle_cnt_q == SI_IDLE_CYC - 1);
   assign si_block    = pulse_q || pulse_start;
   assign SI          = !pulse_q;

   // idle timer restarted by each pop; one SI pulse per burst of sent bytes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_q  <= '0;
         pulse_cnt_q <= '0;
         armed_q     <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         if (pop) idle_cnt_q <= '0;
         else if (idle_tick && idle_cnt_q != SI_IDLE_CYC) idle_cnt_q <= idle_cnt_q + 32'd1;
         if (pop) armed_q <= 1'b1;
         else if (pulse_start) armed_q <= 1'b0;
         if (pulse_start) begin
            pulse_q     <= 1'b1;
            pulse_cnt_q <= '0;
         end else if (pulse_q) begin
            if (pulse_cnt_q == SI_PULSE_CYC - 1) pulse_q <= 1'b0;
            else pulse_cnt_q <= pulse_cnt_q + 32'd1;
         end
      end
   end
`else
   assign SI       = 1'b1;
   assign si_block = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - randomized self-checking bench for usb_tx against a byte-queue reference
module tb_usb_tx;
   localparam int SETUP = 2;
   localparam int WRW   = 5;
   localparam int HOLD  = 1;
   localparam int PERIOD = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       txe;
   logic       wr;
   logic [7:0] d_out;
   logic       d_oe;
   logic       bus_gnt;
   logic       bus_busy;
   logic       SI;
   logic [4:0] fifo_level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit si_low_seen = 0;
   bit oe_bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int width_q[$];
   int setup_q[$];
   int hold_q[$];
   int rise_q[$];

   usb_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .txe       (txe),
      .wr        (wr),
      .d_out     (d_out),
      .d_oe      (d_oe),
      .bus_gnt   (bus_gnt),
      .bus_busy  (bus_busy),
      .SI        (SI),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // bus observer: records write strobes, data latched at WR fall, setup/hold
   initial begin
      logic wr_p;
      logic [7:0] last_d;
      int wr_len, oe_run, hold_cnt;
      bit in_hold;
      wr_p = 0; last_d = 0; wr_len = 0; oe_run = 0; hold_cnt = 0; in_hold = 0;
      forever begin
         @(negedge clk);
         if (SI !== 1'b1) si_low_seen = 1;
         if (!rst_n) begin
            wr_p = 0; wr_len = 0; oe_run = 0; in_hold = 0;
         end else begin
            if (wr && !wr_p) begin
               rise_q.push_back(cyc);
               setup_q.push_back(oe_run);
               wr_len = 0;
            end
            if (wr) begin
               wr_len++;
               last_d = d_out;
               if (!d_oe) oe_bad = 1;
            end
            if (!wr && wr_p) begin
               width_q.push_back(wr_len);
               got_q.push_back(last_d);
               in_hold = 1;
               hold_cnt = 0;
            end
            if (in_hold) begin
               if (d_oe) hold_cnt++;
               else begin
                  hold_q.push_back(hold_cnt);
                  in_hold = 0;
               end
            end
            if (!d_oe) oe_run = 0;
            else if (!wr) oe_run++;
            wr_p = wr;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      exp_q.delete(); got_q.delete(); width_q.delete();
      setup_q.delete(); hold_q.delete(); rise_q.delete();
   endtask

   task automatic push_byte(input logic [7:0] b, output bit to);
      int k = 0;
      to = 0;
      @(negedge clk);
      tx_data = b;
      tx_valid = 1;
      while (!tx_ready) begin
         @(negedge clk);
         k++;
         if (k > 300) begin to = 1; break; end
      end
      @(posedge clk);
      #1;
      tx_valid = 0;
      if (!to) exp_q.push_back(b);
   endtask

   task automatic wait_falls(input int n, input int budget, output bit to);
      int k = 0;
      to = 0;
      while (width_q.size() < n) begin
         @(negedge clk); #1;
         k++;
         if (k > budget) begin to = 1; break; end
      end
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic wait_rise(input int budget, output bit to);
      int k = 0;
      to = 0;
      while (rise_q.size() == 0) begin
         @(negedge clk); #1;
         k++;
         if (k > budget) begin to = 1; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 0; txe = 1; bus_gnt = 0; tx_valid = 0; tx_data = 0;
      repeat (3) @(negedge clk);
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0h exp 0", wr); end
      checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL reset_d_oe got %0h exp 0", d_oe); end
      checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out got %0h exp 0", d_out); end
      checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_bus_busy got %0h exp 0", bus_busy); end
      checks++; if (SI !== 1'b1) begin errors++; $display("FAIL reset_si got %0h exp 1", SI); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %0h exp 1", tx_ready); end
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      bit to;
      clear_obs();
      txe = 0; bus_gnt = 1;
      repeat (3) @(negedge clk);
      push_byte(8'hA5, to);
      checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_level_push got %0d exp 1", fifo_level); end
      wait_falls(1, 100, to);
      checks++; if (to) begin errors++; $display("FAIL single_timeout got 1 exp 0"); end
      checks++; if (width_q[0] !== WRW) begin errors++; $display("FAIL single_wr_width got %0d exp %0d", width_q[0], WRW); end
      checks++; if (setup_q[0] !== SETUP) begin errors++; $display("FAIL single_setup got %0d exp %0d", setup_q[0], SETUP); end
      checks++; if (hold_q[0] !== HOLD) begin errors++; $display("FAIL single_hold got %0d exp %0d", hold_q[0], HOLD); end
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_data got %0h exp %0h", got_q[0], exp_q[0]); end
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_level_pop got %0d exp 0", fifo_level); end
      checks++; if (rise_q.size() !== 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", rise_q.size()); end
   endtask

   task automatic test_back_to_back();
      bit to;
      clear_obs();
      txe = 1; bus_gnt = 1;
      repeat (4) @(negedge clk);
      for (int i = 1; i <= 16; i++) push_byte(8'(i), to);
      @(negedge clk);
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_tx_ready got %0h exp 0", tx_ready); end
      checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL b2b_level got %0d exp 16", fifo_level); end
      txe = 0;
      wait_falls(16, 16 * PERIOD + 60, to);
      checks++; if (to) begin errors++; $display("FAIL b2b_timeout got 1 exp 0"); end
      checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", got_q.size()); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got %0h exp %0h", i, got_q[i], exp_q[i]); end
         checks++; if (width_q[i] !== WRW) begin errors++; $display("FAIL b2b_width[%0d] got %0d exp %0d", i, width_q[i], WRW); end
      end
      for (int i = 1; i < 16; i++) begin
         checks++; if (rise_q[i] - rise_q[i-1] < PERIOD) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d exp >=%0d", i, rise_q[i] - rise_q[i-1], PERIOD); end
      end
      checks++; if (oe_bad) begin errors++; $display("FAIL b2b_oe_during_wr got 0 exp 1"); end
   endtask

   task automatic test_txe_gate();
      bit to, busy_seen;
      int t0;
      clear_obs();
      txe = 1; bus_gnt = 1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) push_byte(8'($urandom), to);
      busy_seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus_busy || wr) busy_seen = 1;
      end
      checks++; if (busy_seen) begin errors++; $display("FAIL txe_hold_busy got 1 exp 0"); end
      checks++; if (rise_q.size() !== 0) begin errors++; $display("FAIL txe_hold_wr got %0d exp 0", rise_q.size()); end
      @(negedge clk);
      txe = 0;
      t0 = cyc;
      wait_rise(60, to);
      checks++; if (to || rise_q[0] - t0 < 3) begin errors++; $display("FAIL txe_start_latency got %0d exp >=3", rise_q[0] - t0); end
      txe = 1;
      wait_falls(1, 60, to);
      checks++; if (width_q[0] !== WRW) begin errors++; $display("FAIL txe_mid_width got %0d exp %0d", width_q[0], WRW); end
      repeat (40) @(negedge clk);
      checks++; if (width_q.size() !== 1) begin errors++; $display("FAIL txe_next_waits got %0d exp 1", width_q.size()); end
      txe = 0;
      wait_falls(3, 3 * PERIOD + 60, to);
      checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL txe_count got %0d exp 3", got_q.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL txe_data[%0d] got %0h exp %0h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_grant();
      bit to;
      logic [7:0] b;
      clear_obs();
      txe = 0; bus_gnt = 0;
      b = 8'($urandom);
      push_byte(b, to);
      repeat (20) @(negedge clk);
      checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL gnt_wait_busy got %0h exp 1", bus_busy); end
      checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL gnt_wait_oe got %0h exp 0", d_oe); end
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL gnt_wait_wr got %0h exp 0", wr); end
      bus_gnt = 1;
      @(negedge clk);
      checks++; if (d_oe !== 1'b1) begin errors++; $display("FAIL gnt_setup_oe got %0h exp 1", d_oe); end
      checks++; if (d_out !== b) begin errors++; $display("FAIL gnt_setup_data got %0h exp %0h", d_out, b); end
      wait_falls(1, 60, to);
      checks++; if (got_q[0] !== b) begin errors++; $display("FAIL gnt_data got %0h exp %0h", got_q[0], b); end
   endtask

   task automatic test_random();
      bit to;
      int n;
      clear_obs();
      txe = 0;
      n = $urandom_range(8, 16);
      for (int i = 0; i < n; i++) begin
         bus_gnt = ($urandom_range(0, 3) != 0);
         push_byte(8'($urandom), to);
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      bus_gnt = 1;
      wait_falls(n, n * PERIOD + 100, to);
      checks++; if (got_q.size() !== n) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %0h exp %0h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_si();
`ifdef SI_FLUSH_EN
      bit to;
      int idle_n, low_n, k;
      clear_obs();
      txe = 0; bus_gnt = 1;
      push_byte(8'($urandom), to);
      wait_falls(1, 60, to);
      idle_n = 0; low_n = 0; k = 0;
      while (SI === 1'b1 && k < 3000) begin
         if (!bus_busy && fifo_level == 0) idle_n++;
         @(negedge clk);
         k++;
      end
      while (SI === 1'b0 && k < 3000) begin
         low_n++;
         @(negedge clk);
         k++;
      end
      checks++; if (idle_n !== 1000) begin errors++; $display("FAIL si_idle_delay got %0d exp 1000", idle_n); end
      checks++; if (low_n !== 5) begin errors++; $display("FAIL si_pulse_width got %0d exp 5", low_n); end
      si_low_seen = 0;
      repeat (1500) @(negedge clk);
      checks++; if (si_low_seen) begin errors++; $display("FAIL si_repeat got 1 exp 0"); end
`else
      repeat (20) @(negedge clk);
      checks++; if (si_low_seen) begin errors++; $display("FAIL si_tied got low exp 1"); end
`endif
   endtask

   task automatic test_reset_mid();
      bit to;
      clear_obs();
      txe = 0; bus_gnt = 1;
      for (int i = 0; i < 3; i++) push_byte(8'($urandom), to);
      wait_rise(60, to);
      checks++; if (to) begin errors++; $display("FAIL rstmid_rise got timeout exp rise"); end
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rstmid_wr_async got %0h exp 0", wr); end
      checks++; if (d_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe_async got %0h exp 0", d_oe); end
      repeat (3) @(negedge clk);
      rst_n = 1;
      clear_obs();
      @(negedge clk);
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rstmid_level got %0d exp 0", fifo_level); end
      repeat (60) @(negedge clk);
      checks++; if (rise_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_wr got %0d exp 0", rise_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_txe_gate();
      test_grant();
      test_random();
      test_si();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
